// File: rtl/mips_pkg.sv
// Shared encodings for the MIPS decode/execute slice.
//   - Opcode and funct field values for the supported instruction subset.
//   - ALUOp encodings from the main decoder to the ALU-control decoder.
//   - 4-bit ALU operation codes consumed by mips_alu_core.
//   - ctrl_t: the bundle of datapath control signals produced by main decode.
package mips_pkg;

    // Opcodes, instr[31:26]
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    // Funct codes, instr[5:0], meaningful only for R-type
    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;
    localparam logic [5:0] FN_NOR = 6'b100111;

    // ALUOp
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    // ALU operation codes
    localparam logic [3:0] ALU_AND     = 4'b0000;
    localparam logic [3:0] ALU_OR      = 4'b0001;
    localparam logic [3:0] ALU_ADD     = 4'b0010;
    localparam logic [3:0] ALU_SUB     = 4'b0110;
    localparam logic [3:0] ALU_SLT     = 4'b0111;
    localparam logic [3:0] ALU_NOR     = 4'b1100;
    localparam logic [3:0] ALU_INVALID = 4'b1111;

    typedef struct packed {
        logic       reg_dst;
        logic       branch;
        logic       mem_to_reg;
        logic       mem_write;
        logic       mem_read;
        logic       alu_src;
        logic       reg_write;
        logic       jump;
        logic [1:0] alu_op;
    } ctrl_t;

endpackage

// File: rtl/mips_alu_core.sv
// Combinational 32-bit MIPS ALU.
// Ports:
//   op_a      in   XLEN  operand 1
//   op_b      in   XLEN  operand 2
//   operation in   4     ALU operation code (mips_pkg ALU_*)
//   result    out  XLEN  ALU result; 0 for ALU_INVALID or unknown codes
//   zero      out  1     result == 0
module mips_alu_core
    import mips_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    input  logic [3:0]      operation,
    output logic [XLEN-1:0] result,
    output logic            zero
);

    logic lt;

    assign lt = $signed(op_a) < $signed(op_b);

    always_comb begin
        result = '0;
        case (operation)
            ALU_AND: result = op_a & op_b;
            ALU_OR:  result = op_a | op_b;
            ALU_ADD: result = op_a + op_b;
            ALU_SUB: result = op_a - op_b;
            ALU_SLT: result = {{(XLEN-1){1'b0}}, lt};
            ALU_NOR: result = ~(op_a | op_b);
            default: result = '0;
        endcase
    end

    assign zero = (result == '0);

endmodule

// File: rtl/mips_decode_exec.sv
// Single-cycle MIPS decode/execute slice with a registered output stage.
// Main decode, ALU-control decode and the ALUSrc mux are combinational; the
// ALU lives in mips_alu_core. Everything is registered once on clk.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid              instruction/operands present this cycle
//   instr                 instruction word (opcode [31:26], funct [5:0])
//   read_data1/2, imm_ext rs value, rt value, sign-extended immediate
//   out_valid             registered in_valid
//   reg_dst..jump, alu_op registered controls, forced to 0 for bubbles
//   alu_operation         registered 4-bit ALU operation
//   alu_result, zero      registered ALU result and zero flag
//   pc_src                registered branch & zero, forced to 0 for bubbles
module mips_decode_exec
    import mips_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    input  logic [31:0]     instr,
    input  logic [XLEN-1:0] read_data1,
    input  logic [XLEN-1:0] read_data2,
    input  logic [XLEN-1:0] imm_ext,
    output logic            out_valid,
    output logic            reg_dst,
    output logic            branch,
    output logic            mem_to_reg,
    output logic            mem_write,
    output logic            mem_read,
    output logic            alu_src,
    output logic            reg_write,
    output logic            jump,
    output logic [1:0]      alu_op,
    output logic [3:0]      alu_operation,
    output logic [XLEN-1:0] alu_result,
    output logic            zero,
    output logic            pc_src
);

    logic [5:0]      opcode;
    logic [5:0]      funct;
    ctrl_t           ctrl_d;
    logic [3:0]      alu_operation_d;
    logic [XLEN-1:0] op_b;
    logic [XLEN-1:0] result_d;
    logic            zero_d;

    // Register fields rs/rt/rd/shamt are consumed outside this block.
    logic unused_instr;
    assign unused_instr = ^instr[25:6];

    assign opcode = instr[31:26];
    assign funct  = instr[5:0];

    // Main decode
    always_comb begin
        ctrl_d = '0;
        case (opcode)
            OP_RTYPE: begin
                ctrl_d.reg_dst   = 1'b1;
                ctrl_d.reg_write = 1'b1;
                ctrl_d.alu_op    = ALUOP_FUNCT;
            end
            OP_LW: begin
                ctrl_d.alu_src    = 1'b1;
                ctrl_d.mem_to_reg = 1'b1;
                ctrl_d.reg_write  = 1'b1;
                ctrl_d.mem_read   = 1'b1;
            end
            OP_SW: begin
                ctrl_d.alu_src   = 1'b1;
                ctrl_d.mem_write = 1'b1;
            end
            OP_BEQ: begin
                ctrl_d.branch = 1'b1;
                ctrl_d.alu_op = ALUOP_SUB;
            end
            OP_ADDI: begin
                ctrl_d.alu_src   = 1'b1;
                ctrl_d.reg_write = 1'b1;
            end
            OP_J: begin
                ctrl_d.jump = 1'b1;
            end
            default: ctrl_d = '0;
        endcase
    end

    // ALU-control decode
    always_comb begin
        alu_operation_d = ALU_INVALID;
        case (ctrl_d.alu_op)
            ALUOP_ADD: alu_operation_d = ALU_ADD;
            ALUOP_SUB: alu_operation_d = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct)
                    FN_ADD:  alu_operation_d = ALU_ADD;
                    FN_SUB:  alu_operation_d = ALU_SUB;
                    FN_AND:  alu_operation_d = ALU_AND;
                    FN_OR:   alu_operation_d = ALU_OR;
                    FN_SLT:  alu_operation_d = ALU_SLT;
                    FN_NOR:  alu_operation_d = ALU_NOR;
                    default: alu_operation_d = ALU_INVALID;
                endcase
            end
            default: alu_operation_d = ALU_INVALID;
        endcase
    end

    assign op_b = ctrl_d.alu_src ? imm_ext : read_data2;

    mips_alu_core #(
        .XLEN(XLEN)
    ) u_alu_core (
        .op_a      (read_data1),
        .op_b      (op_b),
        .operation (alu_operation_d),
        .result    (result_d),
        .zero      (zero_d)
    );

    ctrl_t           ctrl_q;
    logic            valid_q;
    logic [3:0]      alu_operation_q;
    logic [XLEN-1:0] result_q;
    logic            zero_q;
    logic            pc_src_q;

    // Bubbles clear controls and pc_src so nothing downstream acts on them;
    // the ALU side is left free-running since it is ignored without out_valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q         <= 1'b0;
            ctrl_q          <= '0;
            alu_operation_q <= '0;
            result_q        <= '0;
            zero_q          <= 1'b0;
            pc_src_q        <= 1'b0;
        end else begin
            valid_q         <= in_valid;
            ctrl_q          <= in_valid ? ctrl_d : '0;
            alu_operation_q <= alu_operation_d;
            result_q        <= result_d;
            zero_q          <= zero_d;
            pc_src_q        <= in_valid & ctrl_d.branch & zero_d;
        end
    end

    assign out_valid     = valid_q;
    assign reg_dst       = ctrl_q.reg_dst;
    assign branch        = ctrl_q.branch;
    assign mem_to_reg    = ctrl_q.mem_to_reg;
    assign mem_write     = ctrl_q.mem_write;
    assign mem_read      = ctrl_q.mem_read;
    assign alu_src       = ctrl_q.alu_src;
    assign reg_write     = ctrl_q.reg_write;
    assign jump          = ctrl_q.jump;
    assign alu_op        = ctrl_q.alu_op;
    assign alu_operation = alu_operation_q;
    assign alu_result    = result_q;
    assign zero          = zero_q;
    assign pc_src        = pc_src_q;

endmodule

// File: tb/tb_mips_decode_exec.sv
// Directed bench for mips_decode_exec: hand-computed vectors, one-cycle latency.
module tb_mips_decode_exec;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic [31:0] instr;
    logic [31:0] read_data1;
    logic [31:0] read_data2;
    logic [31:0] imm_ext;
    logic        out_valid;
    logic        reg_dst, branch, mem_to_reg, mem_write, mem_read, alu_src, reg_write, jump;
    logic [1:0]  alu_op;
    logic [3:0]  alu_operation;
    logic [31:0] alu_result;
    logic        zero;
    logic        pc_src;

    int n_tests = 0;
    int n_fail  = 0;

    mips_decode_exec #(
        .XLEN(32)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_valid      (in_valid),
        .instr         (instr),
        .read_data1    (read_data1),
        .read_data2    (read_data2),
        .imm_ext       (imm_ext),
        .out_valid     (out_valid),
        .reg_dst       (reg_dst),
        .branch        (branch),
        .mem_to_reg    (mem_to_reg),
        .mem_write     (mem_write),
        .mem_read      (mem_read),
        .alu_src       (alu_src),
        .reg_write     (reg_write),
        .jump          (jump),
        .alu_op        (alu_op),
        .alu_operation (alu_operation),
        .alu_result    (alu_result),
        .zero          (zero),
        .pc_src        (pc_src)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // ctrl order: {reg_dst, branch, mem_to_reg, mem_write, mem_read, alu_src, reg_write, jump}
    task automatic expect_gated(input string tag, input logic ov, input logic [7:0] ctrl,
                                input logic [1:0] aop, input logic pc);
        check({tag, "/out_valid"}, 64'(out_valid), 64'(ov));
        check({tag, "/ctrl"}, 64'({reg_dst, branch, mem_to_reg, mem_write, mem_read, alu_src,
                                   reg_write, jump}), 64'(ctrl));
        check({tag, "/alu_op"}, 64'(alu_op), 64'(aop));
        check({tag, "/pc_src"}, 64'(pc_src), 64'(pc));
    endtask

    task automatic expect_out(input string tag, input logic ov, input logic [7:0] ctrl,
                              input logic [1:0] aop, input logic [3:0] aoper,
                              input logic [31:0] res, input logic zr, input logic pc);
        expect_gated(tag, ov, ctrl, aop, pc);
        check({tag, "/alu_operation"}, 64'(alu_operation), 64'(aoper));
        check({tag, "/alu_result"}, 64'(alu_result), 64'(res));
        check({tag, "/zero"}, 64'(zero), 64'(zr));
    endtask

    // Drive one cycle of inputs, then step to just after the capturing edge.
    task automatic issue(input logic v, input logic [31:0] ins, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] imm);
        in_valid   = v;
        instr      = ins;
        read_data1 = a;
        read_data2 = b;
        imm_ext    = imm;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] rtype(input logic [5:0] fn);
        return {6'b000000, 5'd8, 5'd9, 5'd10, 5'd0, fn};
    endfunction

    function automatic logic [31:0] itype(input logic [5:0] op);
        return {op, 5'd8, 5'd9, 16'h0004};
    endfunction

    initial begin
        rst_n      = 1'b0;
        in_valid   = 1'b0;
        instr      = '0;
        read_data1 = '0;
        read_data2 = '0;
        imm_ext    = '0;
        #1;
        expect_out("reset0", 0, 8'h00, 2'b00, 4'h0, 32'h0, 0, 0);

        @(negedge clk);
        rst_n = 1'b1;

        // Bubbles after reset: gated outputs stay 0 (instr=0 decodes as invalid funct).
        issue(0, 32'h0, 32'h0, 32'h0, 32'h0);
        expect_gated("bubble1", 0, 8'h00, 2'b00, 0);
        check("bubble1/alu_result", 64'(alu_result), 64'h0);
        issue(0, 32'h0, 32'h0, 32'h0, 32'h0);
        expect_gated("bubble2", 0, 8'h00, 2'b00, 0);

        // Back-to-back valid instructions, one per cycle.
        issue(1, 32'h01095020, 32'd5, 32'd7, 32'h0);
        expect_out("add", 1, 8'b1000_0010, 2'b10, 4'b0010, 32'd12, 0, 0);
        issue(1, rtype(6'b100010), 32'd3, 32'd3, 32'h0);
        expect_out("sub", 1, 8'b1000_0010, 2'b10, 4'b0110, 32'd0, 1, 0);
        issue(1, rtype(6'b101010), 32'hFFFF_FFFF, 32'd1, 32'h0);
        expect_out("slt", 1, 8'b1000_0010, 2'b10, 4'b0111, 32'd1, 0, 0);
        issue(1, rtype(6'b101010), 32'd1, 32'hFFFF_FFFF, 32'h0);
        expect_out("slt_rev", 1, 8'b1000_0010, 2'b10, 4'b0111, 32'd0, 1, 0);
        issue(1, rtype(6'b100111), 32'h0, 32'h0, 32'h0);
        expect_out("nor", 1, 8'b1000_0010, 2'b10, 4'b1100, 32'hFFFF_FFFF, 0, 0);
        issue(1, rtype(6'b100100), 32'h0000_F0F0, 32'h0000_FF00, 32'h0);
        expect_out("and", 1, 8'b1000_0010, 2'b10, 4'b0000, 32'h0000_F000, 0, 0);
        issue(1, rtype(6'b100101), 32'h0000_F0F0, 32'h0000_0F00, 32'h0);
        expect_out("or", 1, 8'b1000_0010, 2'b10, 4'b0001, 32'h0000_FFF0, 0, 0);
        issue(1, rtype(6'b000000), 32'd6, 32'd9, 32'h0);
        expect_out("bad_funct", 1, 8'b1000_0010, 2'b10, 4'b1111, 32'd0, 1, 0);

        // Memory ops use imm_ext, not read_data2.
        issue(1, itype(6'b100011), 32'h100, 32'h55, 32'hFFFF_FFFC);
        expect_out("lw", 1, 8'b0010_1110, 2'b00, 4'b0010, 32'h0000_00FC, 0, 0);
        issue(1, itype(6'b101011), 32'h100, 32'h55, 32'hFFFF_FFFC);
        expect_out("sw", 1, 8'b0001_0100, 2'b00, 4'b0010, 32'h0000_00FC, 0, 0);
        issue(1, itype(6'b001000), 32'd10, 32'd77, 32'hFFFF_FFFF);
        expect_out("addi", 1, 8'b0000_0110, 2'b00, 4'b0010, 32'd9, 0, 0);

        issue(1, itype(6'b000100), 32'd9, 32'd9, 32'h4);
        expect_out("beq_taken", 1, 8'b0100_0000, 2'b01, 4'b0110, 32'd0, 1, 1);
        issue(1, itype(6'b000100), 32'd9, 32'd8, 32'h4);
        expect_out("beq_not", 1, 8'b0100_0000, 2'b01, 4'b0110, 32'd1, 0, 0);

        issue(1, itype(6'b000010), 32'd1, 32'd2, 32'h100);
        expect_out("j", 1, 8'b0000_0001, 2'b00, 4'b0010, 32'd3, 0, 0);
        issue(1, itype(6'b111111), 32'd4, 32'd4, 32'h100);
        expect_out("bad_op", 1, 8'b0000_0000, 2'b00, 4'b0010, 32'd8, 0, 0);

        // Bubble carrying a taken branch: controls/pc_src masked, ALU still captured.
        issue(0, itype(6'b000100), 32'd9, 32'd9, 32'h4);
        expect_out("bubble_beq", 0, 8'h00, 2'b00, 4'b0110, 32'd0, 1, 0);

        // Mid-stream reset clears outputs before the next edge.
        issue(1, 32'h01095020, 32'd5, 32'd7, 32'h0);
        expect_out("pre_reset", 1, 8'b1000_0010, 2'b10, 4'b0010, 32'd12, 0, 0);
        #2;
        rst_n = 1'b0;
        #1;
        expect_out("mid_reset", 0, 8'h00, 2'b00, 4'h0, 32'h0, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        issue(1, itype(6'b000100), 32'd5, 32'd5, 32'h0);
        expect_out("post_reset", 1, 8'b0100_0000, 2'b01, 4'b0110, 32'd0, 1, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
